// File: rtl/rfPhoenixPkg.sv
// Shared types and defaults for the rfPhoenix vector ALU scheduler.
package rfPhoenixPkg;

  localparam int VALU_LAT    = 2;
  localparam int VALU_ODEPTH = 4;
  localparam int NLANES      = 16;

  typedef logic [31:0] Value;
  typedef Value [NLANES-1:0] VecValue;
  typedef logic [7:0] ASID;

  // Each flag set replaces that operand with the broadcast immediate.
  typedef struct packed {
    logic tt;
    logic tb;
    logic ta;
  } ttag_t;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_ADD3,
    OP_SEL,
    OP_MASK,
    OP_ASID
  } opcode_t;

  typedef struct packed {
    opcode_t op;
  } instruction_t;

  function automatic VecValue vec_splat(input Value v);
    VecValue r;
    for (int i = 0; i < NLANES; i++) r[i] = v;
    return r;
  endfunction

endpackage

// File: rtl/rfPhoenixVecAlu.sv
// Combinational lane-parallel vector ALU evaluated from the scheduler's issue register.
module rfPhoenixVecAlu
  import rfPhoenixPkg::*;
(
  input  instruction_t ir,
  input  VecValue      a,
  input  VecValue      b,
  input  VecValue      c,
  input  VecValue      t,
  input  Value         imm,
  input  ttag_t        ttag,
  input  ASID          asid,
  input  Value         hmask,
  output VecValue      res
);

  VecValue oa;
  VecValue ob;
  VecValue ot;

  always_comb begin
    oa  = ttag.ta ? vec_splat(imm) : a;
    ob  = ttag.tb ? vec_splat(imm) : b;
    ot  = ttag.tt ? vec_splat(imm) : t;
    res = '0;
    for (int i = 0; i < NLANES; i++) begin
      case (ir.op)
        OP_ADD:  res[i] = oa[i] + ob[i];
        OP_SUB:  res[i] = oa[i] - ob[i];
        OP_AND:  res[i] = oa[i] & ob[i];
        OP_OR:   res[i] = oa[i] | ob[i];
        OP_XOR:  res[i] = oa[i] ^ ob[i];
        OP_ADD3: res[i] = oa[i] + ob[i] + c[i];
        OP_SEL:  res[i] = (ot[i] != '0) ? oa[i] : ob[i];
        OP_MASK: res[i] = oa[i] & hmask;
        OP_ASID: res[i] = Value'(asid);
        default: res[i] = '0;
      endcase
    end
  end

endmodule

// File: rtl/rfphoenix_valu_ofifo.sv
// Result FIFO holding ALU results and their thread ids until the consumer pops them.
module rfphoenix_valu_ofifo
  import rfPhoenixPkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TW    = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  VecValue       wdata,
  input  logic [TW-1:0] wtid,
  input  logic          pop,
  output logic          valid,
  output VecValue       rdata,
  output logic [TW-1:0] rtid,
  output logic [OW-1:0] count
);

  VecValue       mem     [DEPTH];
  logic [TW-1:0] tid_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == OW'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is only legal alongside a pop; an empty FIFO never bypasses.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr]     <= wdata;
      tid_mem[wr_ptr] <= wtid;
    end
  end

  assign valid = !empty;
  assign rdata = empty ? '0 : mem[rd_ptr];
  assign rtid  = empty ? '0 : tid_mem[rd_ptr];

endmodule

// File: rtl/rfphoenix_valu_sched.sv
// Round-robin scheduler sharing one vector ALU between NREQ thread slots, with
// credit-based issue into a fixed-latency pipeline and an in-order result FIFO.
module rfphoenix_valu_sched
  import rfPhoenixPkg::*;
#(
  parameter int NREQ   = 4,
  parameter int LAT    = VALU_LAT,
  parameter int ODEPTH = VALU_ODEPTH,
  localparam int TW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_i,
  output logic [NREQ-1:0]         gnt_o,
  input  instruction_t [NREQ-1:0] ir_i,
  input  VecValue [NREQ-1:0]      a_i,
  input  VecValue [NREQ-1:0]      b_i,
  input  VecValue [NREQ-1:0]      c_i,
  input  VecValue [NREQ-1:0]      t_i,
  input  Value [NREQ-1:0]         imm_i,
  input  ttag_t [NREQ-1:0]        ttag_i,
  input  ASID                     asid_i,
  input  Value                    hmask_i,
  input  logic                    flush_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output VecValue                 res_o,
  output logic [TW-1:0]           res_tid_o,
  output logic                    busy_o
);

  localparam int IW = $clog2(LAT + 2);
  localparam int OW = $clog2(ODEPTH + 1);
  localparam int CW = $clog2(ODEPTH + LAT + 3);

  logic [TW-1:0]   rr_ptr;
  logic [TW-1:0]   gnt_idx;
  logic [TW-1:0]   idx;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic            can_issue;
  logic            xfer;
  logic            push;
  logic            pop;
  logic [IW-1:0]   inflight;
  logic [OW-1:0]   occ;
  logic [CW-1:0]   used;
  logic [CW-1:0]   limit;

  logic            iss_v;
  instruction_t    iss_ir;
  VecValue         iss_a;
  VecValue         iss_b;
  VecValue         iss_c;
  VecValue         iss_t;
  Value            iss_imm;
  ttag_t           iss_ttag;
  ASID             iss_asid;
  Value            iss_hmask;
  logic [TW-1:0]   iss_tid;
  VecValue         alu_res;

  logic [LAT-1:0]  pipe_v;
  VecValue         pipe_res [LAT];
  logic [TW-1:0]   pipe_tid [LAT];

  // A pop this cycle frees its slot at the same edge a new op enters the issue
  // register, so it counts as a credit; otherwise back-to-back issue would stall.
  assign used      = CW'(occ) + CW'(inflight);
  assign limit     = CW'(ODEPTH) + CW'(pop);
  assign can_issue = rst_ni && !flush_i && (used < limit);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    if (can_issue) begin
      for (int i = 1; i <= NREQ; i++) begin
        idx = TW'((int'(rr_ptr) + i) % NREQ);
        if (!gnt_any && req_i[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = idx;
        end
      end
      gnt[gnt_idx] = gnt_any;
    end
  end

  assign gnt_o = gnt;
  assign xfer  = gnt_any;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      iss_v  <= 1'b0;
      rr_ptr <= TW'(NREQ - 1);
    end else begin
      iss_v <= xfer;
      if (xfer) rr_ptr <= gnt_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (xfer) begin
      iss_ir    <= ir_i[gnt_idx];
      iss_a     <= a_i[gnt_idx];
      iss_b     <= b_i[gnt_idx];
      iss_c     <= c_i[gnt_idx];
      iss_t     <= t_i[gnt_idx];
      iss_imm   <= imm_i[gnt_idx];
      iss_ttag  <= ttag_i[gnt_idx];
      iss_asid  <= asid_i;
      iss_hmask <= hmask_i;
      iss_tid   <= gnt_idx;
    end
  end

  rfPhoenixVecAlu u_alu (
    .ir    (iss_ir),
    .a     (iss_a),
    .b     (iss_b),
    .c     (iss_c),
    .t     (iss_t),
    .imm   (iss_imm),
    .ttag  (iss_ttag),
    .asid  (iss_asid),
    .hmask (iss_hmask),
    .res   (alu_res)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= iss_v;
      for (int i = 1; i < LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    pipe_res[0] <= alu_res;
    pipe_tid[0] <= iss_tid;
    for (int i = 1; i < LAT; i++) begin
      pipe_res[i] <= pipe_res[i-1];
      pipe_tid[i] <= pipe_tid[i-1];
    end
  end

  assign push = pipe_v[LAT-1];
  assign pop  = res_valid_o && res_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      inflight <= '0;
    end else if (xfer && !push) begin
      inflight <= inflight + 1'b1;
    end else if (!xfer && push) begin
      inflight <= inflight - 1'b1;
    end
  end

  rfphoenix_valu_ofifo #(
    .DEPTH (ODEPTH),
    .TW    (TW)
  ) u_ofifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .flush (flush_i),
    .push  (push),
    .wdata (pipe_res[LAT-1]),
    .wtid  (pipe_tid[LAT-1]),
    .pop   (pop),
    .valid (res_valid_o),
    .rdata (res_o),
    .rtid  (res_tid_o),
    .count (occ)
  );

  assign busy_o = (inflight != '0) || (occ != '0);

endmodule

// File: tb/tb_rfphoenix_valu_sched.sv
// Directed bench for rfphoenix_valu_sched with hand-computed expectations (NREQ=4, LAT=2, ODEPTH=4).
module tb_rfphoenix_valu_sched;
  import rfPhoenixPkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [3:0]          req;
  logic [3:0]          gnt;
  instruction_t [3:0]  ir;
  VecValue [3:0]       a;
  VecValue [3:0]       b;
  VecValue [3:0]       c;
  VecValue [3:0]       t;
  Value [3:0]          imm;
  ttag_t [3:0]         ttag;
  ASID                 asid;
  Value                hmask;
  logic                flush;
  logic                res_valid;
  logic                res_ready;
  VecValue             res;
  logic [1:0]          res_tid;
  logic                busy;

  int n_cmp = 0;
  int n_bad = 0;

  VecValue e_add;
  VecValue e_sub;
  VecValue e_sel;

  rfphoenix_valu_sched dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .gnt_o       (gnt),
    .ir_i        (ir),
    .a_i         (a),
    .b_i         (b),
    .c_i         (c),
    .t_i         (t),
    .imm_i       (imm),
    .ttag_i      (ttag),
    .asid_i      (asid),
    .hmask_i     (hmask),
    .flush_i     (flush),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_o       (res),
    .res_tid_o   (res_tid),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input VecValue obs, input VecValue exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops;
    for (int k = 0; k < 4; k++) begin
      ir[k].op = OP_ADD;
      a[k]     = '0;
      b[k]     = '0;
      c[k]     = '0;
      t[k]     = '0;
      imm[k]   = '0;
      ttag[k]  = '0;
    end
    asid  = 8'h5A;
    hmask = 32'hFFFF_0000;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req       = '0;
    flush     = 1'b0;
    res_ready = 1'b1;
    clear_ops();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // ---- reset state, then full round-robin with ready held high ----
    do_reset();
    #1;
    chk("rst gnt", gnt, 0);
    chk("rst res_valid", res_valid, 0);
    chk_vec("rst res", res, '0);
    chk("rst tid", res_tid, 0);
    chk("rst busy", busy, 0);
    for (int k = 0; k < 4; k++) a[k] = vec_splat(Value'(100 + k));
    req = 4'b1111;
    for (int cy = 0; cy < 14; cy++) begin
      #1;
      chk($sformatf("rr gnt c%0d", cy), gnt, 32'(1) << (cy % 4));
      chk($sformatf("rr valid c%0d", cy), res_valid, (cy >= 4) ? 1 : 0);
      if (cy >= 4) begin
        chk($sformatf("rr tid c%0d", cy), res_tid, (cy - 4) % 4);
        chk_vec($sformatf("rr res c%0d", cy), res, vec_splat(Value'(100 + (cy - 4) % 4)));
      end
      step();
    end
    req = '0;
    repeat (4) step();
    #1;
    chk("rr drained valid", res_valid, 0);
    chk("rr drained busy", busy, 0);

    // ---- backpressure: 4 credits, fill, then drain while issuing every cycle ----
    do_reset();
    res_ready = 1'b0;
    req = 4'b0001;
    for (int cy = 0; cy < 8; cy++) begin
      a[0] = vec_splat(Value'(200 + cy));
      #1;
      chk($sformatf("bp gnt c%0d", cy), gnt, (cy < 4) ? 1 : 0);
      chk($sformatf("bp valid c%0d", cy), res_valid, (cy >= 4) ? 1 : 0);
      if (cy >= 1) chk($sformatf("bp busy c%0d", cy), busy, 1);
      step();
    end
    res_ready = 1'b1;
    for (int cy = 8; cy < 28; cy++) begin
      a[0] = vec_splat(Value'(200 + cy));
      #1;
      chk($sformatf("bp resume gnt c%0d", cy), gnt, 1);
      chk($sformatf("bp stream valid c%0d", cy), res_valid, 1);
      chk_vec($sformatf("bp stream res c%0d", cy), res,
              vec_splat(Value'((cy < 12) ? 200 + cy - 8 : 200 + cy - 4)));
      step();
    end
    req = '0;
    for (int cy = 28; cy < 32; cy++) begin
      #1;
      chk($sformatf("bp tail gnt c%0d", cy), gnt, 0);
      chk($sformatf("bp tail valid c%0d", cy), res_valid, 1);
      chk_vec($sformatf("bp tail res c%0d", cy), res, vec_splat(Value'(200 + cy - 4)));
      step();
    end
    #1;
    chk("bp end valid", res_valid, 0);
    chk("bp end busy", busy, 0);

    // ---- flush after two transfers ----
    do_reset();
    a[0] = vec_splat(32'd300);
    a[1] = vec_splat(32'd301);
    a[2] = vec_splat(32'd302);
    req = 4'b0011;
    #1; chk("fl gnt c0", gnt, 4'b0001); step();
    #1; chk("fl gnt c1", gnt, 4'b0010); step();
    flush = 1'b1;
    #1;
    chk("fl gnt during flush", gnt, 0);
    chk("fl busy before flush", busy, 1);
    step();
    flush = 1'b0;
    req = '0;
    #1;
    chk("fl busy after flush", busy, 0);
    chk("fl valid after flush", res_valid, 0);
    step();
    for (int cy = 4; cy < 7; cy++) begin
      #1; chk($sformatf("fl no result c%0d", cy), res_valid, 0); step();
    end
    req = 4'b1111;
    #1; chk("fl next gnt", gnt, 4'b0100); step();
    req = '0;
    repeat (3) step();
    #1;
    chk("fl next valid", res_valid, 1);
    chk("fl next tid", res_tid, 2);
    chk_vec("fl next res", res, vec_splat(32'd302));
    step();
    #1;
    chk("fl end valid", res_valid, 0);
    chk("fl end busy", busy, 0);

    // ---- ALU datapath: ADD, SUB with scalar imm, SEL ----
    do_reset();
    for (int i = 0; i < NLANES; i++) begin
      a[2][i]  = Value'(i + 1);
      b[2][i]  = Value'(16 - i);
      a[1][i]  = Value'(i + 1);
      t[3][i]  = Value'(i % 2);
      e_sub[i] = Value'(i + 1) - 32'd5;
      e_sel[i] = (i % 2 == 1) ? 32'd7 : 32'd9;
    end
    e_add = vec_splat(32'd17);
    ir[1].op = OP_SUB;
    ttag[1].tb = 1'b1;
    imm[1] = 32'd5;
    ir[3].op = OP_SEL;
    a[3] = vec_splat(32'd7);
    b[3] = vec_splat(32'd9);
    req = 4'b1110;
    #1; chk("alu gnt c0", gnt, 4'b0010); step();
    #1; chk("alu gnt c1", gnt, 4'b0100); step();
    #1; chk("alu gnt c2", gnt, 4'b1000); step();
    req = '0;
    step();
    #1;
    chk("alu sub valid", res_valid, 1);
    chk("alu sub tid", res_tid, 1);
    chk_vec("alu sub res", res, e_sub);
    step();
    #1;
    chk("alu add tid", res_tid, 2);
    chk_vec("alu add res", res, e_add);
    step();
    #1;
    chk("alu sel tid", res_tid, 3);
    chk_vec("alu sel res", res, e_sel);
    step();
    #1;
    chk("alu end valid", res_valid, 0);

    // ---- reset with three operations in flight ----
    do_reset();
    for (int k = 0; k < 4; k++) a[k] = vec_splat(Value'(500 + k));
    req = 4'b1111;
    #1; chk("mr gnt c0", gnt, 4'b0001); step();
    #1; chk("mr gnt c1", gnt, 4'b0010); step();
    #1; chk("mr gnt c2", gnt, 4'b0100); step();
    rst_n = 1'b0;
    #1; chk("mr gnt in reset", gnt, 0); step();
    rst_n = 1'b1;
    #1;
    chk("mr post valid", res_valid, 0);
    chk_vec("mr post res", res, '0);
    chk("mr post tid", res_tid, 0);
    chk("mr post busy", busy, 0);
    chk("mr first gnt", gnt, 4'b0001);
    step();
    req = '0;
    for (int cy = 5; cy < 8; cy++) begin
      #1; chk($sformatf("mr discarded c%0d", cy), res_valid, 0); step();
    end
    #1;
    chk("mr new valid", res_valid, 1);
    chk("mr new tid", res_tid, 0);
    chk_vec("mr new res", res, vec_splat(32'd500));
    step();
    #1;
    chk("mr end valid", res_valid, 0);
    chk("mr end busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
